// File: rtl/alu_pkg.sv
// Shared ALU definitions for the sequential divider: widths, FSM states and
// the divide-by-zero quotient pattern.
package alu_pkg;
    localparam int DIV_WIDTH = 16;
    localparam int DIV_ITERS = 16;
    localparam logic [DIV_WIDTH-1:0] DIV_ZERO_Q = 16'hFFFF;

    typedef enum logic [1:0] {
        DIV_IDLE,
        DIV_CALC,
        DIV_FIX
    } div_state_e;
endpackage

// File: rtl/seq_divider_16bit_if.sv
// Request/result bundle between the execute stage (master) and the divider (slave).
interface seq_divider_16bit_if #(parameter int WIDTH = 16);
    logic             start;
    logic             signed_op;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             busy;
    logic             done;
    logic             div_zero;
    logic             ovfl;

    modport master (
        output start, signed_op, dividend, divisor,
        input  quotient, remainder, busy, done, div_zero, ovfl
    );
    modport slave (
        input  start, signed_op, dividend, divisor,
        output quotient, remainder, busy, done, div_zero, ovfl
    );
endinterface

// File: rtl/div_step.sv
// One restoring-division iteration: shift in the next dividend bit, trial
// subtract, keep the difference or restore depending on its sign.
module div_step #(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] rem_i,
    input  logic [WIDTH-1:0] q_i,
    input  logic [WIDTH-1:0] dvsr_i,
    output logic [WIDTH-1:0] rem_next_o,
    output logic [WIDTH-1:0] q_next_o
);
    logic [WIDTH:0] shifted;
    logic [WIDTH:0] trial;
    logic           borrow;

    // shifted < 2*dvsr, so the 17-bit difference is always in signed range
    assign shifted    = {rem_i, q_i[WIDTH-1]};
    assign trial      = shifted - {1'b0, dvsr_i};
    assign borrow     = trial[WIDTH];
    assign rem_next_o = borrow ? shifted[WIDTH-1:0] : trial[WIDTH-1:0];
    assign q_next_o   = {q_i[WIDTH-2:0], ~borrow};
endmodule

// File: rtl/seq_divider_16bit.sv
// Iterative signed/unsigned restoring divider, one quotient bit per clock,
// with start/done handshake and registered, held results.
module seq_divider_16bit
    import alu_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input logic                clk,
    input logic                rst,
    seq_divider_16bit_if.slave bus
);
    localparam int ITER_W = $clog2(WIDTH) + 1;

    div_state_e       state_q, state_d;
    logic [ITER_W-1:0] iter_q, iter_d;
    logic [WIDTH-1:0] rem_q, rem_d, q_q, q_d, dvsr_q, dvsr_d;
    logic             q_neg_q, q_neg_d, r_neg_q, r_neg_d;
    logic             dz_q, dz_d, ov_q, ov_d;
    logic [WIDTH-1:0] quot_q, quot_d, remo_q, remo_d;
    logic             busy_q, busy_d, done_q, done_d;
    logic             divz_q, divz_d, ovfl_q, ovfl_d;
    logic [WIDTH-1:0] rem_next, q_next;
    logic             sd, sv;

    div_step #(.WIDTH(WIDTH)) u_step (
        .rem_i      (rem_q),
        .q_i        (q_q),
        .dvsr_i     (dvsr_q),
        .rem_next_o (rem_next),
        .q_next_o   (q_next)
    );

    assign sd = bus.signed_op & bus.dividend[WIDTH-1];
    assign sv = bus.signed_op & bus.divisor[WIDTH-1];

    always_comb begin
        state_d = state_q;
        iter_d  = iter_q;
        rem_d   = rem_q;
        q_d     = q_q;
        dvsr_d  = dvsr_q;
        q_neg_d = q_neg_q;
        r_neg_d = r_neg_q;
        dz_d    = dz_q;
        ov_d    = ov_q;
        quot_d  = quot_q;
        remo_d  = remo_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        divz_d  = divz_q;
        ovfl_d  = ovfl_q;
        case (state_q)
            DIV_IDLE: begin
                if (bus.start) begin
                    busy_d = 1'b1;
                    divz_d = 1'b0;
                    ovfl_d = 1'b0;
                    iter_d = '0;
                    if (bus.divisor == '0) begin
                        // preload the fixed result so FIX passes it through unchanged
                        rem_d   = bus.dividend;
                        q_d     = DIV_ZERO_Q;
                        q_neg_d = 1'b0;
                        r_neg_d = 1'b0;
                        dz_d    = 1'b1;
                        ov_d    = 1'b0;
                        state_d = DIV_FIX;
                    end else begin
                        rem_d   = '0;
                        q_d     = sd ? -bus.dividend : bus.dividend;
                        dvsr_d  = sv ? -bus.divisor : bus.divisor;
                        q_neg_d = sd ^ sv;
                        r_neg_d = sd;
                        dz_d    = 1'b0;
                        ov_d    = bus.signed_op && (bus.dividend == {1'b1, {(WIDTH-1){1'b0}}})
                                  && (bus.divisor == '1);
                        state_d = DIV_CALC;
                    end
                end
            end
            DIV_CALC: begin
                rem_d  = rem_next;
                q_d    = q_next;
                iter_d = iter_q + ITER_W'(1);
                if (iter_q == ITER_W'(DIV_ITERS - 1)) state_d = DIV_FIX;
            end
            DIV_FIX: begin
                quot_d  = q_neg_q ? -q_q : q_q;
                remo_d  = r_neg_q ? -rem_q : rem_q;
                done_d  = 1'b1;
                busy_d  = 1'b0;
                divz_d  = dz_q;
                ovfl_d  = ov_q;
                state_d = DIV_IDLE;
            end
            default: state_d = DIV_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= DIV_IDLE;
            iter_q  <= '0;
            rem_q   <= '0;
            q_q     <= '0;
            dvsr_q  <= '0;
            q_neg_q <= 1'b0;
            r_neg_q <= 1'b0;
            dz_q    <= 1'b0;
            ov_q    <= 1'b0;
            quot_q  <= '0;
            remo_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            divz_q  <= 1'b0;
            ovfl_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            iter_q  <= iter_d;
            rem_q   <= rem_d;
            q_q     <= q_d;
            dvsr_q  <= dvsr_d;
            q_neg_q <= q_neg_d;
            r_neg_q <= r_neg_d;
            dz_q    <= dz_d;
            ov_q    <= ov_d;
            quot_q  <= quot_d;
            remo_q  <= remo_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            divz_q  <= divz_d;
            ovfl_q  <= ovfl_d;
        end
    end

    assign bus.quotient  = quot_q;
    assign bus.remainder = remo_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.div_zero  = divz_q;
    assign bus.ovfl      = ovfl_q;
endmodule
